bcd2bin: RTL and testbench
==========================

# bcd2bin

Sequential converter that takes a packed 2-digit BCD value (the `{tens, ones}` byte produced by the team's BCD counters) and returns its 7-bit binary equivalent. It uses the reverse double-dabble method: a shift right, then a subtract-3 correction per digit, one bit per clock. It sits between BCD counter outputs and any binary consumer (comparators, arithmetic, bus registers). A start/busy/done handshake controls it.

## Interface
- Parameters: none. The format is fixed at 2 BCD digits in and 7 binary bits out.
- `clk`  input  1  sole clock; all state updates on rising edge
- `reset`  input  1  synchronous, active-low reset; sampled on rising edge of `clk`
- `start`  input  1  request a conversion; sampled only in IDLE
- `bcd_in`  input  8  `[7:4]` tens digit, `[3:0]` ones digit; captured on the accepting edge
- `bin_out`  output  7  last conversion result, 0..99; held until next completion
- `busy`  output  1  high while a conversion is in progress
- `done`  output  1  one-cycle pulse when `bin_out`/`err` update
- `err`  output  1  invalid-digit flag for the last conversion (see Configuration)

## Operation
- Internal state:
  - 15-bit shift register `{bcd[7:0], bin[6:0]}`
  - 3-bit iteration counter
  - FSM with states IDLE, SHIFT, FIN
  - error-pending flag
- IDLE, with `start`=1 and a valid input:
  - load `{bcd_in, 7'b0}`
  - counter ← 0, `busy` ← 1
  - go to SHIFT
- SHIFT, each cycle:
  - shift the whole 15-bit register right by 1 (bcd LSB enters bin MSB)
  - then, for each 4-bit BCD nibble ≥ 8, subtract 3 from that nibble
  - counter increments
  - after the 7th shift, go to FIN
- FIN:
  - `bin_out` ← bin field, `err` ← error-pending, `done` ← 1, `busy` ← 0
  - clear error-pending
  - go to IDLE
- `done` is cleared on the next edge unconditionally.
- `start` in SHIFT or FIN is ignored; it is not queued.
- `bcd_in` changes after the accepting edge have no effect.
- A valid input always yields `bin_out` = 10·tens + ones.
- Reset (`reset`=0 at an edge) takes priority over everything:
  - state IDLE
  - `bin_out`=0, `busy`=0, `done`=0, `err`=0
  - shift register, counter and error-pending cleared
  - A conversion in progress is aborted with no `done`.

## Timing
- Edge 0: `start` is accepted in IDLE; `busy`=1 after edge 0.
- Edges 1..7: the seven shift/correct steps.
- Edge 8: FIN registers the result. `done`=1 and `busy`=0 during the cycle after edge 8.
- Edge 9: `done` returns to 0. A `start` present at edge 9 is accepted, giving one conversion per 9 cycles.
- Invalid input (macro enabled):
  - accepted at edge 0 straight into FIN with error-pending set
  - edge 1: `done`=1, `err`=1, `bin_out`=0
  - latency 1; `busy` stays 0

## Configuration
- Macro: `BCD2BIN_CHECK_EN`.
- When defined:
  - On acceptance, either nibble > 9 is flagged as invalid.
  - Invalid inputs skip SHIFT and produce `bin_out`=0, `err`=1 with 1-cycle latency.
  - Valid inputs give `err`=0.
- When undefined:
  - No digit check; every input takes the 8-cycle SHIFT path.
  - `err` is constant 0.
  - `bin_out` for invalid digits is whatever the algorithm produces and is not verified.

## Test plan
- Reset held low 2 cycles, then released → `bin_out`=0, `busy`=0, `done`=0, `err`=0; no activity without `start`.
- `start` with `bcd_in`=0x99, then separately 0x00, 0x10, 0x57 → each gives `done` high exactly one cycle, 8 edges after acceptance, with `bin_out`=99, 0, 10, 57 and `err`=0. Then sweep all 100 valid codes against 10·tens+ones.
- `start` with 0x42, `start` reasserted at edge 3 with `bcd_in`=0x11 → a single `done`, `bin_out`=42; `busy` high for edges 0..8 only.
- `reset`=0 at edge 4 of a conversion of 0x63 → all outputs 0 and no `done`. Then `start` with 0x25 → `bin_out`=25 after 8 edges.
- With `BCD2BIN_CHECK_EN`, `start` with 0x3A and with 0xA0 → `done`=1 and `err`=1 at edge 1, `bin_out`=0. A following 0x07 clears `err` and gives `bin_out`=7. Without the macro, `err` never rises.
- `start` held high continuously with `bcd_in`=0x12 → conversions accepted at edges 0, 9, 18…; `done` pulses each time; `bin_out` stays 12 between pulses.

Source files
------------

// File: rtl/bcd2bin_if.sv
// bcd2bin_if: handshake bundle for the BCD-to-binary converter.
//   start   : request a conversion (client -> converter)
//   bcd_in  : packed {tens, ones} BCD byte (client -> converter)
//   bin_out : binary result 0..99 (converter -> client)
//   busy    : conversion in progress
//   done    : one-cycle completion pulse
//   err     : invalid-digit flag for the last conversion
interface bcd2bin_if;
   logic       start;
   logic [7:0] bcd_in;
   logic [6:0] bin_out;
   logic       busy;
   logic       done;
   logic       err;

   modport master (output start, bcd_in, input bin_out, busy, done, err);
   modport slave  (input start, bcd_in, output bin_out, busy, done, err);
endinterface

// File: rtl/bcd2bin.sv
// bcd2bin: sequential 2-digit BCD to 7-bit binary converter using reverse
// double-dabble (shift right, then subtract 3 from any BCD nibble >= 8),
// one bit per clock. Nine cycles per conversion: accept, 7 shifts, finish.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous, active-low
//   bus   : bcd2bin_if.slave (start, bcd_in in; bin_out, busy, done, err out)
// Optional feature: define BCD2BIN_CHECK_EN to flag digits > 9. Flagged
// inputs skip the shift phase and finish one edge later with bin_out=0,
// err=1. Without it err is always 0 and every input is shifted.
module bcd2bin (
   input logic       clk,
   input logic       reset,
   bcd2bin_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;

   state_t      state;
   logic [14:0] sr;        // {bcd[7:0], bin[6:0]}
   logic [2:0]  cnt;
   logic        err_pend;
   logic [6:0]  bin_q;
   logic        busy_q;
   logic        done_q;
   logic        err_q;

   logic [14:0] sr_shf;
   logic [14:0] sr_nxt;
   logic        in_bad;

   // One reverse double-dabble step: shift, then correct each BCD nibble
   // that received a bit worth 8 (it should have been worth 5).
   always_comb begin
      sr_shf = {1'b0, sr[14:1]};
      sr_nxt = sr_shf;
      if (sr_shf[14:11] >= 4'd8) sr_nxt[14:11] = sr_shf[14:11] - 4'd3;
      if (sr_shf[10:7]  >= 4'd8) sr_nxt[10:7]  = sr_shf[10:7]  - 4'd3;
   end

`ifdef BCD2BIN_CHECK_EN
   assign in_bad = (bus.bcd_in[7:4] > 4'd9) || (bus.bcd_in[3:0] > 4'd9);
`else
   assign in_bad = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= IDLE;
         sr       <= '0;
         cnt      <= '0;
         err_pend <= 1'b0;
         bin_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  sr  <= {bus.bcd_in, 7'b0};
                  cnt <= '0;
                  if (in_bad) begin
                     // bin field is loaded as zero, so FIN reports 0
                     err_pend <= 1'b1;
                     state    <= FIN;
                  end else begin
                     busy_q <= 1'b1;
                     state  <= SHIFT;
                  end
               end
            end
            SHIFT: begin
               sr  <= sr_nxt;
               cnt <= cnt + 3'd1;
               if (cnt == 3'd6) state <= FIN;   // 7th shift done
            end
            FIN: begin
               bin_q    <= sr[6:0];
               err_q    <= err_pend;
               done_q   <= 1'b1;
               busy_q   <= 1'b0;
               err_pend <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.bin_out = bin_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.err     = err_q;

endmodule

// File: tb/tb_bcd2bin.sv
// tb_bcd2bin: scoreboard bench for bcd2bin. Expected {bin, err} pairs are
// queued when a conversion is requested and popped on each done pulse.
module tb_bcd2bin;

   typedef struct {
      logic [6:0] bin;
      logic       err;
   } exp_t;

   logic clk;
   logic reset;
   bcd2bin_if bus ();

   bcd2bin dut (.clk(clk), .reset(reset), .bus(bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   exp_t sb[$];
   int   n_chk = 0;
   int   n_err = 0;
   logic prev_done = 1'b0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // Scoreboard side: every done pulse must match the oldest request.
   always @(negedge clk) begin
      if (reset && bus.done) begin
         chk("done_width", {31'b0, prev_done}, 0);
         if (sb.size() == 0) begin
            chk("spurious_done", 1, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("bin_out", {25'b0, bus.bin_out}, {25'b0, e.bin});
            chk("err", {31'b0, bus.err}, {31'b0, e.err});
         end
      end
      prev_done = bus.done;
   end

   // Issue one conversion and measure the accept-to-done latency.
   task automatic convert(input logic [7:0] code, input int lat_exp);
      exp_t e;
      int   lat;
      logic bad;
      bad = (code[7:4] > 4'd9) || (code[3:0] > 4'd9);
      e.bin = bad ? 7'd0 : 7'(code[7:4] * 10 + code[3:0]);
`ifdef BCD2BIN_CHECK_EN
      e.err = bad;
`else
      e.err = 1'b0;
`endif
      @(negedge clk);
      bus.start  = 1'b1;
      bus.bcd_in = code;
      sb.push_back(e);
      @(posedge clk);
      #1;
      bus.start  = 1'b0;
      bus.bcd_in = 8'($urandom);
      chk("busy_accept", {31'b0, bus.busy}, (lat_exp == 8) ? 1 : 0);
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
      end while (!bus.done && lat < 20);
      chk("latency", lat, lat_exp);
      chk("busy_done", {31'b0, bus.busy}, 0);
   endtask

   initial begin
      int dpos[$];
      int ndone;
      logic [3:0] t4, o4;
      exp_t e;

      reset      = 1'b0;
      bus.start  = 1'b0;
      bus.bcd_in = 8'h00;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("rst_bin", {25'b0, bus.bin_out}, 0);
      chk("rst_busy", {31'b0, bus.busy}, 0);
      chk("rst_done", {31'b0, bus.done}, 0);
      chk("rst_err", {31'b0, bus.err}, 0);

      // directed values
      convert(8'h99, 8);
      convert(8'h00, 8);
      convert(8'h10, 8);
      convert(8'h57, 8);

      // full sweep of valid codes
      for (int t = 0; t < 10; t++)
         for (int o = 0; o < 10; o++) begin
            t4 = 4'(t);
            o4 = 4'(o);
            convert({t4, o4}, 8);
         end

      // start re-asserted mid-conversion is ignored
      @(negedge clk);
      bus.start = 1'b1; bus.bcd_in = 8'h42;
      e.bin = 7'd42; e.err = 1'b0; sb.push_back(e);
      @(posedge clk); #1 bus.start = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         if (k == 3) begin bus.start = 1'b1; bus.bcd_in = 8'h11; end
         @(posedge clk); #1;
         if (k == 3) bus.start = 1'b0;
         if (k <= 8) chk("busy_42", {31'b0, bus.busy}, (k < 8) ? 1 : 0);
         if (k == 8) chk("done_42", {31'b0, bus.done}, 1);
      end
      chk("sb_42", sb.size(), 0);

      // reset aborts a conversion with no done
      @(negedge clk);
      bus.start = 1'b1; bus.bcd_in = 8'h63;
      @(posedge clk); #1 bus.start = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk); #1 reset = 1'b1;
      chk("abort_bin", {25'b0, bus.bin_out}, 0);
      chk("abort_busy", {31'b0, bus.busy}, 0);
      chk("abort_err", {31'b0, bus.err}, 0);
      ndone = 0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk); #1;
         if (bus.done) ndone++;
      end
      chk("abort_nodone", ndone, 0);
      convert(8'h25, 8);

`ifdef BCD2BIN_CHECK_EN
      convert(8'h3A, 1);
      convert(8'hA0, 1);
      convert(8'h07, 8);
`endif

      // back-to-back conversions with start held high
      @(negedge clk);
      bus.start = 1'b1; bus.bcd_in = 8'h12;
      e.bin = 7'd12; e.err = 1'b0;
      repeat (3) sb.push_back(e);
      for (int k = 0; k <= 30; k++) begin
         @(posedge clk); #1;
         if (k == 18) bus.start = 1'b0;
         if (bus.done) dpos.push_back(k);
         if (k >= 8) chk("hold_12", {25'b0, bus.bin_out}, 12);
      end
      chk("b2b_count", dpos.size(), 3);
      if (dpos.size() == 3) begin
         chk("b2b_pos0", dpos[0], 8);
         chk("b2b_pos1", dpos[1], 17);
         chk("b2b_pos2", dpos[2], 26);
      end

      repeat (3) @(posedge clk);
      #1 chk("sb_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
